pwm_preconditioner: RTL

Converts per-transducer duty/phase/cycle settings into the rise/fall edge times consumed by each channel's `pwm_buffer`. It sequentially scans a settings memory, computes wrapped edge times in a pipeline at one channel per clock, and holds the results in a registered array. `pwm_buffer` latches that array at its own period boundary.

---
 rtl/pwm_preconditioner.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pwm_preconditioner.sv
// pwm_preconditioner
//   Scans a settings memory one channel per clock and turns each channel's
//   duty/phase/cycle into the rise/fall edge times used by pwm_buffer.
//   The results are held in registered per-channel arrays.
//
// Ports
//   CLK, RST           clock, synchronous active-high reset
//   START              one-cycle request to recompute all channels (IDLE only)
//   ADDR               settings-memory read address (memory has 1-cycle latency)
//   DUTY/PHASE/CYCLE   memory data for the address presented on the previous cycle
//   RISE_OUT/FALL_OUT  registered edge times, one entry per channel
//   BUSY               high while a scan is in progress
//   DONE               one-cycle pulse when the last channel's result is visible
module pwm_preconditioner #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  output logic [$clog2(DEPTH)-1:0]   ADDR,
  input  logic [WIDTH-1:0]           DUTY,
  input  logic [WIDTH-1:0]           PHASE,
  input  logic [WIDTH-1:0]           CYCLE,
  output logic [WIDTH-1:0]           RISE_OUT [DEPTH],
  output logic [WIDTH-1:0]           FALL_OUT [DEPTH],
  output logic                       BUSY,
  output logic                       DONE
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    cnt_q, cnt_d;

  // ---------------- control FSM ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    DONE    = 1'b0;
    case (state_q)
      IDLE: if (START) begin
        state_d = RUN;
        addr_d  = '0;
      end
      RUN: begin
        if (addr_q == LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        // three drain cycles let the last read clear stage A and the write
        if (cnt_q == 2'd2) begin
          state_d = IDLE;
          DONE    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ADDR = addr_q;
  assign BUSY = (state_q != IDLE);

  // ---------------- valid/index pipeline ----------------
  // vld_pipe_q[0]: memory data valid this cycle, vld_pipe_q[1]: stage A valid
  // (its result is written at the end of that cycle).
  logic [1:0]         vld_pipe_q;
  logic [1:0][AW-1:0] idx_pipe_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_pipe_q <= '0;
      idx_pipe_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], state_q == RUN};
      idx_pipe_q <= {idx_pipe_q[0], addr_q};
    end
  end

  // ---------------- stage A: clamp and halve ----------------
  logic [WIDTH-1:0] d_c, p_c, hd_c, hu_c;
  logic [WIDTH-1:0] d_q, p_q, hd_q, hu_q, cyc_q;

  assign d_c  = (DUTY < CYCLE) ? DUTY : CYCLE;
  assign p_c  = (PHASE >= CYCLE) ? '0 : PHASE;
  assign hd_c = d_c >> 1;
  // d may equal 2^WIDTH-1, so round-up halving needs one extra bit
  assign hu_c = WIDTH'(({1'b0, d_c} + (WIDTH+1)'(1)) >> 1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      d_q   <= '0;
      p_q   <= '0;
      hd_q  <= '0;
      hu_q  <= '0;
      cyc_q <= '0;
    end else begin
      d_q   <= d_c;
      p_q   <= p_c;
      hd_q  <= hd_c;
      hu_q  <= hu_c;
      cyc_q <= CYCLE;
    end
  end

  // ---------------- stage B: wrapped edges ----------------
  logic [WIDTH:0]   s_x, cyc_x;
  logic [WIDTH-1:0] rise_c, fall_c;

  assign s_x   = {1'b0, p_q} + {1'b0, hu_q};
  assign cyc_x = {1'b0, cyc_q};

  always_comb begin
    // p < cycle and hd <= cycle/2, so p + (cycle - hd) wraps into range
    // without ever exceeding WIDTH bits when p < hd.
    rise_c = (p_q >= hd_q) ? (p_q - hd_q) : (p_q + (cyc_q - hd_q));
    fall_c = (s_x >= cyc_x) ? WIDTH'(s_x - cyc_x) : WIDTH'(s_x);
    if (cyc_q == '0 || d_q == '0) begin
      rise_c = '0;
      fall_c = '0;
    end else if (d_q == cyc_q) begin
      // full duty: [0, cycle) covers every time slot
      rise_c = '0;
      fall_c = cyc_q;
    end
  end

  logic [WIDTH-1:0] rise_q [DEPTH];
  logic [WIDTH-1:0] fall_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        rise_q[i] <= '0;
        fall_q[i] <= '0;
      end
    end else if (vld_pipe_q[1]) begin
      rise_q[idx_pipe_q[1]] <= rise_c;
      fall_q[idx_pipe_q[1]] <= fall_c;
    end
  end

  assign RISE_OUT = rise_q;
  assign FALL_OUT = fall_q;

endmodule
